// File: rtl/ex_mdu_pkg.sv
// Shared opcode, result-class and divider-state definitions for the
// execution stage with multiply/divide support.
package ex_mdu_pkg;

    localparam logic [7:0] EXE_NOP_OP   = 8'b0000_0000;
    localparam logic [7:0] EXE_AND_OP   = 8'b0010_0100;
    localparam logic [7:0] EXE_OR_OP    = 8'b0010_0101;
    localparam logic [7:0] EXE_XOR_OP   = 8'b0010_0110;
    localparam logic [7:0] EXE_NOR_OP   = 8'b0010_0111;
    localparam logic [7:0] EXE_SLL_OP   = 8'b0111_1100;
    localparam logic [7:0] EXE_SRL_OP   = 8'b0000_0010;
    localparam logic [7:0] EXE_SRA_OP   = 8'b0000_0011;
    localparam logic [7:0] EXE_MULT_OP  = 8'b0001_1000;
    localparam logic [7:0] EXE_MULTU_OP = 8'b0001_1001;
    localparam logic [7:0] EXE_DIV_OP   = 8'b0001_1010;
    localparam logic [7:0] EXE_DIVU_OP  = 8'b0001_1011;

    localparam logic [2:0] EXE_RES_NOP   = 3'b000;
    localparam logic [2:0] EXE_RES_LOGIC = 3'b001;
    localparam logic [2:0] EXE_RES_SHIFT = 3'b010;

    typedef enum logic [1:0] {
        DIV_IDLE = 2'b00,
        DIV_BUSY = 2'b01,
        DIV_DONE = 2'b10
    } div_state_t;

    function automatic logic is_div_op(input logic [7:0] op);
        return (op == EXE_DIV_OP) || (op == EXE_DIVU_OP);
    endfunction

endpackage

// File: rtl/ex_mdu_div.sv
// Iterative restoring divider: one quotient bit per cycle on operand
// magnitudes, with a signed fix-up applied to the stored result.
module div_iter
    import ex_mdu_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              signed_op,
    input  logic              annul,
    input  logic [DATA_W-1:0] dividend,
    input  logic [DATA_W-1:0] divisor,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] quotient,
    output logic [DATA_W-1:0] remainder
);

    localparam int CW = $clog2(DATA_W);

    div_state_t state, next_state;

    logic [DATA_W-1:0] quo, rem, dsr;
    logic [CW-1:0]     cnt;
    logic              neg_q, neg_r;
    logic              div_zero, last_step;
    logic [DATA_W-1:0] dividend_mag, divisor_mag;
    logic [DATA_W:0]   shifted, diff;

    assign div_zero     = (divisor == '0);
    assign last_step    = (cnt == CW'(DATA_W - 1));
    assign dividend_mag = (signed_op && dividend[DATA_W-1]) ? -dividend : dividend;
    assign divisor_mag  = (signed_op && divisor[DATA_W-1])  ? -divisor  : divisor;

    // quo doubles as the dividend shift register; its MSB feeds the remainder
    assign shifted = {rem, quo[DATA_W-1]};
    assign diff    = shifted - {1'b0, dsr};

    always_ff @(posedge clk) begin
        if (rst) state <= DIV_IDLE;
        else     state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            DIV_IDLE: if (start) next_state = div_zero ? DIV_DONE : DIV_BUSY;
            DIV_BUSY: begin
                if (annul)          next_state = DIV_IDLE;
                else if (last_step) next_state = DIV_DONE;
            end
            DIV_DONE: next_state = DIV_IDLE;
            default:  next_state = DIV_IDLE;
        endcase
    end

    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        case (state)
            DIV_IDLE: busy = start;
            DIV_BUSY: busy = ~annul;
            DIV_DONE: done = ~annul;
            default:  busy = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            quo   <= '0;
            rem   <= '0;
            dsr   <= '0;
            cnt   <= '0;
            neg_q <= 1'b0;
            neg_r <= 1'b0;
        end else begin
            case (state)
                DIV_IDLE: begin
                    if (start && div_zero) begin
                        quo   <= '1;
                        rem   <= dividend;
                        neg_q <= 1'b0;
                        neg_r <= 1'b0;
                    end else if (start) begin
                        quo   <= dividend_mag;
                        rem   <= '0;
                        dsr   <= divisor_mag;
                        cnt   <= '0;
                        neg_q <= signed_op & (dividend[DATA_W-1] ^ divisor[DATA_W-1]);
                        neg_r <= signed_op & dividend[DATA_W-1];
                    end
                end
                DIV_BUSY: begin
                    cnt <= cnt + 1'b1;
                    if (!diff[DATA_W]) begin
                        rem <= diff[DATA_W-1:0];
                        quo <= {quo[DATA_W-2:0], 1'b1};
                    end else begin
                        rem <= shifted[DATA_W-1:0];
                        quo <= {quo[DATA_W-2:0], 1'b0};
                    end
                end
                default: ;
            endcase
        end
    end

    assign quotient  = neg_q ? -quo : quo;
    assign remainder = neg_r ? -rem : rem;

endmodule

// File: rtl/ex_mdu.sv
// Execution stage: logic, shift and single-cycle multiply datapath plus an
// iterative divider that stalls the pipeline and writes the HI/LO pair.
module ex_mdu
    import ex_mdu_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int AW     = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        aluop_i,
    input  logic [2:0]        alusel_i,
    input  logic [AW-1:0]     wd_i,
    input  logic              wreg_i,
    input  logic [DATA_W-1:0] reg1_i,
    input  logic [DATA_W-1:0] reg2_i,
    input  logic              annul_i,
    output logic [AW-1:0]     wd_o,
    output logic              wreg_o,
    output logic [DATA_W-1:0] wdata_o,
    output logic              whilo_o,
    output logic [DATA_W-1:0] hi_o,
    output logic [DATA_W-1:0] lo_o,
    output logic              stallreq_o
);

    localparam int SHW = $clog2(DATA_W);

    logic [SHW-1:0]      shamt;
    logic [DATA_W-1:0]   logic_res, shift_res;
    logic [2*DATA_W-1:0] mul_a, mul_b, prod;
    logic                is_mult, mult_signed;
    logic                div_busy, div_done;
    logic [DATA_W-1:0]   div_quo, div_rem;

    assign shamt       = reg1_i[SHW-1:0];
    assign is_mult     = (aluop_i == EXE_MULT_OP) || (aluop_i == EXE_MULTU_OP);
    assign mult_signed = (aluop_i == EXE_MULT_OP);

    // Sign- or zero-extending to full width lets one unsigned multiplier serve both
    assign mul_a = mult_signed ? {{DATA_W{reg1_i[DATA_W-1]}}, reg1_i} : {{DATA_W{1'b0}}, reg1_i};
    assign mul_b = mult_signed ? {{DATA_W{reg2_i[DATA_W-1]}}, reg2_i} : {{DATA_W{1'b0}}, reg2_i};
    assign prod  = mul_a * mul_b;

    always_comb begin
        logic_res = '0;
        case (aluop_i)
            EXE_OR_OP:  logic_res = reg1_i | reg2_i;
            EXE_AND_OP: logic_res = reg1_i & reg2_i;
            EXE_XOR_OP: logic_res = reg1_i ^ reg2_i;
            EXE_NOR_OP: logic_res = ~(reg1_i | reg2_i);
            default:    logic_res = '0;
        endcase
    end

    always_comb begin
        shift_res = '0;
        case (aluop_i)
            EXE_SLL_OP: shift_res = reg2_i << shamt;
            EXE_SRL_OP: shift_res = reg2_i >> shamt;
            EXE_SRA_OP: shift_res = $signed(reg2_i) >>> shamt;
            default:    shift_res = '0;
        endcase
    end

    div_iter #(.DATA_W(DATA_W)) u_div (
        .clk       (clk),
        .rst       (rst),
        .start     (is_div_op(aluop_i)),
        .signed_op (aluop_i == EXE_DIV_OP),
        .annul     (annul_i),
        .dividend  (reg1_i),
        .divisor   (reg2_i),
        .busy      (div_busy),
        .done      (div_done),
        .quotient  (div_quo),
        .remainder (div_rem)
    );

    always_comb begin
        wd_o       = '0;
        wreg_o     = 1'b0;
        wdata_o    = '0;
        whilo_o    = 1'b0;
        hi_o       = '0;
        lo_o       = '0;
        stallreq_o = 1'b0;
        if (!rst) begin
            wd_o       = wd_i;
            wreg_o     = wreg_i;
            stallreq_o = div_busy;
            case (alusel_i)
                EXE_RES_LOGIC: wdata_o = logic_res;
                EXE_RES_SHIFT: wdata_o = shift_res;
                default:       wdata_o = '0;
            endcase
            if (is_mult) begin
                whilo_o = 1'b1;
                hi_o    = prod[2*DATA_W-1:DATA_W];
                lo_o    = prod[DATA_W-1:0];
            end else if (div_done) begin
                whilo_o = 1'b1;
                hi_o    = div_rem;
                lo_o    = div_quo;
            end
        end
    end

endmodule

// File: tb/tb_ex_mdu.sv
// Bench for ex_mdu: directed literal cases plus randomized instruction
// streams compared each cycle against a behavioural model.
module tb_ex_mdu;
    import ex_mdu_pkg::*;

    localparam int W  = 32;
    localparam int AW = 5;

    logic          clk = 1'b0;
    logic          rst;
    logic [7:0]    aluop_i;
    logic [2:0]    alusel_i;
    logic [AW-1:0] wd_i;
    logic          wreg_i;
    logic [W-1:0]  reg1_i, reg2_i;
    logic          annul_i;
    logic [AW-1:0] wd_o;
    logic          wreg_o;
    logic [W-1:0]  wdata_o;
    logic          whilo_o;
    logic [W-1:0]  hi_o, lo_o;
    logic          stallreq_o;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    ex_mdu #(.DATA_W(W), .AW(AW)) dut (
        .clk        (clk),
        .rst        (rst),
        .aluop_i    (aluop_i),
        .alusel_i   (alusel_i),
        .wd_i       (wd_i),
        .wreg_i     (wreg_i),
        .reg1_i     (reg1_i),
        .reg2_i     (reg2_i),
        .annul_i    (annul_i),
        .wd_o       (wd_o),
        .wreg_o     (wreg_o),
        .wdata_o    (wdata_o),
        .whilo_o    (whilo_o),
        .hi_o       (hi_o),
        .lo_o       (lo_o),
        .stallreq_o (stallreq_o)
    );

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    // Reference functions computed from the arithmetic definitions
    function automatic logic isDiv(input logic [7:0] op);
        return (op == EXE_DIV_OP) || (op == EXE_DIVU_OP);
    endfunction

    function automatic logic isMult(input logic [7:0] op);
        return (op == EXE_MULT_OP) || (op == EXE_MULTU_OP);
    endfunction

    function automatic logic [W-1:0] refWdata(input logic [2:0] sel, input logic [7:0] op,
                                              input logic [W-1:0] a, input logic [W-1:0] b);
        int     sh;
        longint sb;
        sh = int'(a % 32);
        sb = longint'($signed(b));
        if (sel == EXE_RES_LOGIC) begin
            if (op == EXE_OR_OP)  return a | b;
            if (op == EXE_AND_OP) return a & b;
            if (op == EXE_XOR_OP) return a ^ b;
            if (op == EXE_NOR_OP) return ~(a | b);
        end else if (sel == EXE_RES_SHIFT) begin
            if (op == EXE_SLL_OP) return b << sh;
            if (op == EXE_SRL_OP) return b >> sh;
            if (op == EXE_SRA_OP) return 32'(sb >>> sh);
        end
        return '0;
    endfunction

    function automatic logic [63:0] refMult(input logic [7:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        longint sp;
        logic [63:0] up;
        sp = longint'($signed(a)) * longint'($signed(b));
        up = {32'b0, a} * {32'b0, b};
        return (op == EXE_MULT_OP) ? 64'(sp) : up;
    endfunction

    // Returns {remainder, quotient}
    function automatic logic [63:0] refDiv(input logic [7:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        longint sa, sb, q, r;
        if (b == 0) return {a, 32'hFFFF_FFFF};
        if (op == EXE_DIV_OP) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            q  = sa / sb;
            r  = sa % sb;
            return {32'(r), 32'(q)};
        end
        return {a % b, a / b};
    endfunction

    // Model: cycles left in the current divide (0 = none, 1 = result cycle)
    int          mdl_cnt = 0;
    logic [63:0] mdl_res = '0;

    always @(posedge clk) begin
        if (rst) begin
            mdl_cnt <= 0;
        end else if (mdl_cnt == 0) begin
            if (isDiv(aluop_i)) begin
                mdl_cnt <= (reg2_i == 0) ? 1 : W + 1;
                mdl_res <= refDiv(aluop_i, reg1_i, reg2_i);
            end
        end else if (annul_i) begin
            mdl_cnt <= 0;
        end else begin
            mdl_cnt <= mdl_cnt - 1;
        end
    end

    always @(negedge clk) begin
        logic        exp_stall, exp_whilo;
        logic [63:0] exp_hl;
        if (rst) begin
            checkOutput("rst_wdata", 64'(wdata_o), 64'h0);
            checkOutput("rst_ctrl", 64'({wd_o, wreg_o, whilo_o, stallreq_o}), 64'h0);
            checkOutput("rst_hilo", {hi_o, lo_o}, 64'h0);
        end else begin
            exp_hl    = '0;
            exp_whilo = 1'b0;
            if (mdl_cnt == 0)     exp_stall = isDiv(aluop_i);
            else if (mdl_cnt > 1) exp_stall = ~annul_i;
            else                  exp_stall = 1'b0;
            if (mdl_cnt == 1) begin
                exp_whilo = ~annul_i;
                exp_hl    = mdl_res;
            end else if (isMult(aluop_i)) begin
                exp_whilo = 1'b1;
                exp_hl    = refMult(aluop_i, reg1_i, reg2_i);
            end
            checkOutput("pass_wd", 64'({wd_o, wreg_o}), 64'({wd_i, wreg_i}));
            checkOutput("wdata", 64'(wdata_o), 64'(refWdata(alusel_i, aluop_i, reg1_i, reg2_i)));
            checkOutput("stallreq", 64'(stallreq_o), 64'(exp_stall));
            checkOutput("whilo", 64'(whilo_o), 64'(exp_whilo));
            if (exp_whilo) checkOutput("hilo", {hi_o, lo_o}, exp_hl);
        end
    end

    task automatic applyStimulus(input logic [7:0] op, input logic [2:0] sel,
                                 input logic [W-1:0] a, input logic [W-1:0] b);
        aluop_i  = op;
        alusel_i = sel;
        reg1_i   = a;
        reg2_i   = b;
        wd_i     = AW'($urandom);
        wreg_i   = 1'($urandom);
        annul_i  = 1'b0;
    endtask

    task automatic stepCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic checkWdata(input string name, input logic [7:0] op, input logic [2:0] sel,
                              input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] req);
        applyStimulus(op, sel, a, b);
        @(negedge clk);
        checkOutput(name, 64'(wdata_o), 64'(req));
        stepCycle();
    endtask

    // Drives one divide and holds it while stallreq_o is high
    task automatic runDiv(input logic [7:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                          output int stalls, output int pulses, output logic [W-1:0] hi, output logic [W-1:0] lo);
        applyStimulus(op, EXE_RES_NOP, a, b);
        stalls = 0;
        pulses = 0;
        hi     = '0;
        lo     = '0;
        for (int j = 0; j < 100; j++) begin
            logic s;
            @(negedge clk);
            s = stallreq_o;
            if (s) stalls++;
            if (whilo_o) begin
                pulses++;
                hi = hi_o;
                lo = lo_o;
            end
            stepCycle();
            if (!s) return;
        end
        checkOutput("div_timeout", 64'h1, 64'h0);
    endtask

    task automatic runRandomDiv(input logic [7:0] op, input logic [2:0] sel,
                                input logic [W-1:0] a, input logic [W-1:0] b);
        int k;
        applyStimulus(op, sel, a, b);
        k = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, W + 1)) : 0;
        for (int j = 0; j < 100; j++) begin
            logic s;
            annul_i = (k != 0) && (j == k);
            @(negedge clk);
            s = stallreq_o;
            stepCycle();
            annul_i = 1'b0;
            if (!s) return;
            reg1_i = $urandom;
            reg2_i = $urandom;
        end
        checkOutput("rdiv_timeout", 64'h1, 64'h0);
    endtask

    initial begin
        int          st, pu;
        logic [W-1:0] hi, lo, a, b;
        logic [7:0]  op;
        logic [2:0]  sel;

        rst = 1'b1;
        applyStimulus(EXE_OR_OP, EXE_RES_LOGIC, 32'hFFFF_0000, 32'h0000_1234);
        repeat (3) stepCycle();
        @(negedge clk);
        checkOutput("reset_wdata", 64'(wdata_o), 64'h0);
        checkOutput("reset_stall", 64'(stallreq_o), 64'h0);
        stepCycle();
        rst = 1'b0;

        checkWdata("or", EXE_OR_OP, EXE_RES_LOGIC, 32'hF0F0_0000, 32'h0000_0F0F, 32'hF0F0_0F0F);
        checkWdata("nor", EXE_NOR_OP, EXE_RES_LOGIC, 32'h0, 32'h0, 32'hFFFF_FFFF);
        checkWdata("bad_sel", EXE_OR_OP, 3'b111, 32'h1234_5678, 32'h0F0F_0F0F, 32'h0);
        checkWdata("sra", EXE_SRA_OP, EXE_RES_SHIFT, 32'd4, 32'h8000_0000, 32'hF800_0000);
        checkWdata("sll31", EXE_SLL_OP, EXE_RES_SHIFT, 32'd31, 32'd1, 32'h8000_0000);
        checkWdata("sll33", EXE_SLL_OP, EXE_RES_SHIFT, 32'd33, 32'd1, 32'd2);

        applyStimulus(EXE_MULT_OP, EXE_RES_NOP, 32'hFFFF_FFFD, 32'd5);
        @(negedge clk);
        checkOutput("mult_hilo", {hi_o, lo_o}, 64'hFFFF_FFFF_FFFF_FFF1);
        checkOutput("mult_whilo", 64'(whilo_o), 64'h1);
        stepCycle();
        applyStimulus(EXE_MULTU_OP, EXE_RES_NOP, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        @(negedge clk);
        checkOutput("multu_hilo", {hi_o, lo_o}, 64'hFFFF_FFFE_0000_0001);
        stepCycle();

        runDiv(EXE_DIV_OP, 32'hFFFF_FFF9, 32'd2, st, pu, hi, lo);
        checkOutput("div_stalls", 64'(st), 64'd33);
        checkOutput("div_pulses", 64'(pu), 64'd1);
        checkOutput("div_hilo", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);
        runDiv(EXE_DIVU_OP, 32'd7, 32'd2, st, pu, hi, lo);
        checkOutput("divu_stalls", 64'(st), 64'd33);
        checkOutput("divu_hilo", {hi, lo}, 64'h0000_0001_0000_0003);
        runDiv(EXE_DIVU_OP, 32'd9, 32'd0, st, pu, hi, lo);
        checkOutput("div0_stalls", 64'(st), 64'd1);
        checkOutput("div0_hilo", {hi, lo}, 64'h0000_0009_FFFF_FFFF);
        runDiv(EXE_DIV_OP, 32'h8000_0000, 32'hFFFF_FFFF, st, pu, hi, lo);
        checkOutput("divmin_hilo", {hi, lo}, 64'h0000_0000_8000_0000);

        applyStimulus(EXE_DIV_OP, EXE_RES_NOP, 32'd100, 32'd7);
        repeat (10) stepCycle();
        annul_i = 1'b1;
        @(negedge clk);
        checkOutput("annul_stall", 64'(stallreq_o), 64'h0);
        checkOutput("annul_whilo", 64'(whilo_o), 64'h0);
        stepCycle();
        applyStimulus(EXE_NOP_OP, EXE_RES_NOP, 32'd0, 32'd0);
        @(negedge clk);
        checkOutput("post_annul", 64'({stallreq_o, whilo_o}), 64'h0);
        stepCycle();

        applyStimulus(EXE_DIV_OP, EXE_RES_NOP, 32'd1000, 32'd3);
        repeat (5) stepCycle();
        rst = 1'b1;
        stepCycle();
        @(negedge clk);
        checkOutput("rst_mid_div", 64'({stallreq_o, whilo_o, wreg_o}), 64'h0);
        stepCycle();
        rst = 1'b0;
        applyStimulus(EXE_NOP_OP, EXE_RES_NOP, 32'd0, 32'd0);
        repeat (3) stepCycle();
        runDiv(EXE_DIVU_OP, 32'd1000, 32'd3, st, pu, hi, lo);
        checkOutput("div_after_rst", {hi, lo, 32'(st)} == {32'd1, 32'd333, 32'd33} ? 64'h1 : 64'h0, 64'h1);

        for (int n = 0; n < 300; n++) begin
            a = $urandom;
            b = $urandom;
            case ($urandom_range(0, 3))
                0:       sel = EXE_RES_NOP;
                1:       sel = EXE_RES_LOGIC;
                2:       sel = EXE_RES_SHIFT;
                default: sel = 3'($urandom_range(3, 7));
            endcase
            case ($urandom_range(0, 10))
                0:  op = EXE_AND_OP;
                1:  op = EXE_OR_OP;
                2:  op = EXE_XOR_OP;
                3:  op = EXE_NOR_OP;
                4:  op = EXE_SLL_OP;
                5:  op = EXE_SRL_OP;
                6:  op = EXE_SRA_OP;
                7:  op = EXE_MULT_OP;
                8:  op = EXE_MULTU_OP;
                9:  op = EXE_DIV_OP;
                default: op = EXE_DIVU_OP;
            endcase
            if (isDiv(op)) begin
                case ($urandom_range(0, 7))
                    0: b = '0;
                    1: begin a = 32'h8000_0000; b = '1; end
                    2: b = $urandom_range(1, 15);
                    3: b = -$urandom_range(1, 15);
                    default: ;
                endcase
                runRandomDiv(op, sel, a, b);
            end else begin
                applyStimulus(op, sel, a, b);
                stepCycle();
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
